// File: rtl/prbs_pkg.sv
// +----------------------------------------------------------------------------+
// | prbs_pkg : shared types and standard PRBS tap masks for the LFSR gen/chk   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package prbs_pkg;

    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } chk_state_t;

    localparam logic [6:0]  PRBS7  = 7'h60;
    localparam logic [14:0] PRBS15 = 15'h6000;
    localparam logic [22:0] PRBS23 = 23'h420000;
    localparam logic [30:0] PRBS31 = 31'h48000000;

endpackage

`default_nettype wire

// File: rtl/lfsr_step.sv
// +----------------------------------------------------------------------------+
// | lfsr_step : one combinational Fibonacci LFSR step with selectable shift-in |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module lfsr_step #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] POLY  = 16'hB400
) (
    input  logic [WIDTH-1:0] i_state,
    input  logic             i_in,
    output logic [WIDTH-1:0] o_next,
    output logic             o_fb
);

    // The shift-in bit is an input so the checker can choose between the
    // received bit (hunting) and its own prediction (free-running reference).
    assign o_fb   = ^(i_state & POLY);
    assign o_next = {i_state[WIDTH-2:0], i_in};

endmodule

`default_nettype wire

// File: rtl/prbs_lfsr_gen_chk.sv
// +----------------------------------------------------------------------------+
// | prbs_lfsr_gen_chk : Fibonacci LFSR PRBS generator plus self-aligning       |
// |                     checker with lock/loss detection and error counting    |
// | Revision          : 1.0                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module prbs_lfsr_gen_chk
    import prbs_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] POLY     = 16'hB400,
    parameter logic [WIDTH-1:0] SEED     = WIDTH'(1),
    parameter int               LOCK_CNT = 32,
    parameter int               WIN_LEN  = 256,
    parameter int               LOSS_THR = 16,
    parameter int               ERR_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             gen_en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] gen_state,
    output logic             gen_bit,
    input  logic             chk_en,
    input  logic             chk_bit,
    input  logic             clr_err,
    output logic             chk_locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int c_FILL_W = $clog2(WIDTH + 1);
    localparam int c_MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int c_WIN_W = $clog2(WIN_LEN);
    localparam int c_LOSS_W = $clog2(LOSS_THR + 1);

    localparam logic [c_FILL_W-1:0]  c_FILL_FULL  = c_FILL_W'(WIDTH);
    localparam logic [c_MATCH_W-1:0] c_MATCH_LAST = c_MATCH_W'(LOCK_CNT - 1);
    localparam logic [c_WIN_W-1:0]   c_WIN_LAST   = c_WIN_W'(WIN_LEN - 1);
    localparam logic [c_LOSS_W-1:0]  c_LOSS_LAST  = c_LOSS_W'(LOSS_THR - 1);

    // ---------------------------------------------------------------- generator
    logic [WIDTH-1:0] r_gen_state;
    logic [WIDTH-1:0] w_gen_next;
    logic             w_gen_fb;

    lfsr_step #(
        .WIDTH (WIDTH),
        .POLY  (POLY)
    ) u_gen_step (
        .i_state (r_gen_state),
        .i_in    (w_gen_fb),
        .o_next  (w_gen_next),
        .o_fb    (w_gen_fb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gen_state <= SEED;
        end else if (load) begin
            r_gen_state <= (seed == '0) ? SEED : seed;
        end else if (gen_en) begin
            // An all-zero state would lock up forever; restart from SEED.
            r_gen_state <= (r_gen_state == '0) ? SEED : w_gen_next;
        end
    end

    assign gen_state = r_gen_state;
    assign gen_bit   = r_gen_state[WIDTH-1];

    // ------------------------------------------------------------------ checker
    chk_state_t           r_state,     w_state_nxt;
    logic [WIDTH-1:0]     r_chk_sr,    w_chk_sr_nxt;
    logic [c_FILL_W-1:0]  r_fill,      w_fill_nxt;
    logic [c_MATCH_W-1:0] r_match,     w_match_nxt;
    logic [c_WIN_W-1:0]   r_win,       w_win_nxt;
    logic [c_LOSS_W-1:0]  r_loss,      w_loss_nxt;
    logic [ERR_W-1:0]     r_err_cnt,   w_err_cnt_nxt;
    logic                 r_err_pulse, w_err;
    logic [WIDTH-1:0]     w_chk_next;
    logic                 w_pred;
    logic                 w_chk_in;

    assign w_chk_in = (r_state == LOCKED) ? w_pred : chk_bit;

    lfsr_step #(
        .WIDTH (WIDTH),
        .POLY  (POLY)
    ) u_chk_step (
        .i_state (r_chk_sr),
        .i_in    (w_chk_in),
        .o_next  (w_chk_next),
        .o_fb    (w_pred)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= HUNT;
            r_chk_sr    <= '0;
            r_fill      <= '0;
            r_match     <= '0;
            r_win       <= '0;
            r_loss      <= '0;
            r_err_cnt   <= '0;
            r_err_pulse <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_chk_sr    <= w_chk_sr_nxt;
            r_fill      <= w_fill_nxt;
            r_match     <= w_match_nxt;
            r_win       <= w_win_nxt;
            r_loss      <= w_loss_nxt;
            r_err_cnt   <= w_err_cnt_nxt;
            r_err_pulse <= w_err;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_chk_sr_nxt  = r_chk_sr;
        w_fill_nxt    = r_fill;
        w_match_nxt   = r_match;
        w_win_nxt     = r_win;
        w_loss_nxt    = r_loss;
        w_err_cnt_nxt = r_err_cnt;
        w_err         = 1'b0;

        if (chk_en) begin
            w_chk_sr_nxt = w_chk_next;
            case (r_state)
                HUNT: begin
                    if (r_fill != c_FILL_FULL) begin
                        w_fill_nxt = r_fill + c_FILL_W'(1);
                    end
                    if ((r_fill == c_FILL_FULL) && (w_pred == chk_bit)) begin
                        if (r_match == c_MATCH_LAST) begin
                            w_state_nxt = LOCKED;
                            w_match_nxt = '0;
                            w_win_nxt   = '0;
                            w_loss_nxt  = '0;
                        end else begin
                            w_match_nxt = r_match + c_MATCH_W'(1);
                        end
                    end else begin
                        w_match_nxt = '0;
                    end
                end
                default: begin
                    w_err     = (w_pred != chk_bit);
                    w_win_nxt = r_win + c_WIN_W'(1);
                    if (w_err && (r_err_cnt != '1)) begin
                        w_err_cnt_nxt = r_err_cnt + ERR_W'(1);
                    end
                    // Threshold loss takes priority over the window-wrap reset.
                    if (w_err && (r_loss == c_LOSS_LAST)) begin
                        w_state_nxt = HUNT;
                        w_fill_nxt  = '0;
                        w_match_nxt = '0;
                        w_loss_nxt  = '0;
                    end else if (r_win == c_WIN_LAST) begin
                        w_loss_nxt = '0;
                    end else if (w_err) begin
                        w_loss_nxt = r_loss + c_LOSS_W'(1);
                    end
                end
            endcase
        end

        if (clr_err) begin
            w_err_cnt_nxt = '0;
            w_win_nxt     = '0;
            w_loss_nxt    = '0;
        end
    end

    assign chk_locked = (r_state == LOCKED);
    assign err_pulse  = r_err_pulse;
    assign err_cnt    = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_prbs_lfsr_gen_chk.sv
// +----------------------------------------------------------------------------+
// | tb_prbs_lfsr_gen_chk : scoreboard bench for the 4-bit PRBS gen/checker     |
// | Revision             : 1.0                                                 |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_prbs_lfsr_gen_chk;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       gen_en, load, chk_en, clr_err, flip;
    logic [3:0] seed;
    logic [3:0] gen_state;
    logic       gen_bit, chk_bit, chk_locked, err_pulse;
    logic [3:0] err_cnt;

    always #5 clk = ~clk;

    // Loopback with an optional injected bit inversion.
    assign chk_bit = gen_bit ^ flip;

    prbs_lfsr_gen_chk #(
        .WIDTH (4),
        .POLY  (4'hC),
        .SEED  (4'h1),
        .ERR_W (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .gen_en     (gen_en),
        .load       (load),
        .seed       (seed),
        .gen_state  (gen_state),
        .gen_bit    (gen_bit),
        .chk_en     (chk_en),
        .chk_bit    (chk_bit),
        .clr_err    (clr_err),
        .chk_locked (chk_locked),
        .err_pulse  (err_pulse),
        .err_cnt    (err_cnt)
    );

    typedef struct {
        string      tag;
        bit         cg;
        logic [3:0] g;
        logic       lk;
        logic       ep;
        logic [3:0] ec;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One expected record per driven cycle, describing outputs after the next edge.
    task automatic cyc(input logic ge, input logic ld, input logic [3:0] sd,
                       input logic ce, input logic fl, input logic cl,
                       input string tag, input bit cg, input logic [3:0] g,
                       input logic lk, input logic ep, input logic [3:0] ec);
        exp_t e;
        @(negedge clk);
        gen_en  = ge;
        load    = ld;
        seed    = sd;
        chk_en  = ce;
        flip    = fl;
        clr_err = cl;
        e.tag = tag;
        e.cg  = cg;
        e.g   = g;
        e.lk  = lk;
        e.ep  = ep;
        e.ec  = ec;
        q.push_back(e);
    endtask

    always @(posedge clk) begin : mon
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.cg) check({e.tag, "_gen"}, 32'(gen_state), 32'(e.g));
            check({e.tag, "_lock"}, 32'(chk_locked), 32'(e.lk));
            check({e.tag, "_pulse"}, 32'(err_pulse), 32'(e.ep));
            check({e.tag, "_cnt"}, 32'(err_cnt), 32'(e.ec));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] seq [16];
        seq = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};

        rst_n = 1'b1; gen_en = 0; load = 0; seed = 0; chk_en = 0; clr_err = 0; flip = 0;
        #1 rst_n = 1'b0;
        #22;
        check("rst_gen", 32'(gen_state), 32'h1);
        check("rst_lock", 32'(chk_locked), 32'h0);
        check("rst_pulse", 32'(err_pulse), 32'h0);
        check("rst_cnt", 32'(err_cnt), 32'h0);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 1; i < 16; i++)
            cyc(1, 0, 4'h0, 0, 0, 0, "gen_seq", 1, seq[i], 0, 0, 4'h0);
        cyc(0, 0, 4'h0, 0, 0, 0, "gen_hold", 1, 4'h1, 0, 0, 4'h0);
        cyc(1, 0, 4'h0, 0, 0, 0, "gen_step", 1, 4'h2, 0, 0, 4'h0);
        cyc(0, 1, 4'h0, 0, 0, 0, "load_zero", 1, 4'h1, 0, 0, 4'h0);
        cyc(1, 1, 4'h5, 0, 0, 0, "load_5", 1, 4'h5, 0, 0, 4'h0);
        cyc(1, 0, 4'h0, 0, 0, 0, "after_load", 1, 4'hB, 0, 0, 4'h0);

        // WIDTH fill bits plus LOCK_CNT matches.
        for (int k = 1; k <= 36; k++)
            cyc(1, 0, 4'h0, 1, 0, 0, "lock_acq", 0, 4'h0, logic'(k >= 36), 0, 4'h0);
        for (int k = 0; k < 5; k++)
            cyc(1, 0, 4'h0, 1, 0, 0, "locked", 0, 4'h0, 1, 0, 4'h0);

        cyc(1, 0, 4'h0, 1, 1, 0, "flip1", 0, 4'h0, 1, 1, 4'h1);
        for (int k = 0; k < 4; k++)
            cyc(1, 0, 4'h0, 1, 0, 0, "after_flip", 0, 4'h0, 1, 0, 4'h1);
        cyc(1, 0, 4'h0, 1, 0, 1, "clr_err", 0, 4'h0, 1, 0, 4'h0);
        cyc(1, 0, 4'h0, 1, 0, 0, "post_clr", 0, 4'h0, 1, 0, 4'h0);

        // Sixteen consecutive errors: counter saturates at 15, lock lost on the 16th.
        for (int k = 1; k <= 16; k++)
            cyc(1, 0, 4'h0, 1, 1, 0, "invert", 0, 4'h0, logic'(k < 16), 1,
                (k >= 15) ? 4'hF : 4'(k));
        for (int k = 1; k <= 36; k++)
            cyc(1, 0, 4'h0, 1, 0, 0, "relock", 0, 4'h0, logic'(k >= 36), 0, 4'hF);

        cyc(1, 0, 4'h0, 1, 0, 1, "clr_sat", 0, 4'h0, 1, 0, 4'h0);
        for (int k = 0; k < 2; k++)
            cyc(0, 0, 4'h0, 0, 1, 0, "chk_idle", 0, 4'h0, 1, 0, 4'h0);
        for (int k = 0; k < 3; k++)
            cyc(1, 0, 4'h0, 1, 0, 0, "resume", 0, 4'h0, 1, 0, 4'h0);
        cyc(1, 0, 4'h0, 1, 1, 0, "flip2", 0, 4'h0, 1, 1, 4'h1);
        cyc(1, 0, 4'h0, 1, 0, 0, "after_flip2", 0, 4'h0, 1, 0, 4'h1);

        @(posedge clk);
        #3;
        check("queue_drain", 32'(q.size()), 32'h0);

        // Asynchronous reset away from any clock edge.
        rst_n = 1'b0;
        #1;
        check("midrst_gen", 32'(gen_state), 32'h1);
        check("midrst_lock", 32'(chk_locked), 32'h0);
        check("midrst_pulse", 32'(err_pulse), 32'h0);
        check("midrst_cnt", 32'(err_cnt), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
